// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 encodings used by every pipeline register of the core:
// instruction codes, status codes and the "no register" ID.
// Ports: none (package).
// ---------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Status codes
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    // Register ID meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    // Pipeline-register action for one cycle, in priority order
    typedef enum logic [1:0] {
        PR_LOAD   = 2'd0,
        PR_STALL  = 2'd1,
        PR_BUBBLE = 2'd2
    } preg_act_e;

    // Resolve the per-cycle action: reset and bubble both load the NOP value,
    // stall holds, otherwise the register loads from decode.
    function automatic preg_act_e preg_action(input logic rst,
                                              input logic bubble,
                                              input logic stall);
        if (rst || bubble)
            return PR_BUBBLE;
        else if (stall)
            return PR_STALL;
        else
            return PR_LOAD;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// ---------------------------------------------------------------------------
// pipe_sat_cnt
// Saturating up-counter with synchronous clear; sticks at all-ones.
// Ports:
//   clk  in   rising-edge clock
//   clr  in   synchronous clear (wins over en)
//   en   in   count enable
//   cnt  out  CNT_W-bit count value
// ---------------------------------------------------------------------------
module pipe_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    // Increment that holds at the top value instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        else
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (en)
            cnt <= sat_inc(cnt);
    end

endmodule

// File: rtl/pipe_e_reg.sv
// ---------------------------------------------------------------------------
// pipe_e_reg
// Decode-to-execute pipeline register of the Y86-64 pipelined core with
// synchronous reset, stall (hold), bubble (NOP injection), a valid flag and
// a sticky control-error flag raised when stall and bubble collide.
//
// Optional feature: define PIPE_E_PERF_CNT_EN to add the saturating
// stall_cnt / bubble_cnt performance counters (CNT_W bits each).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   e_stall, e_bubble        pipeline control (bubble wins over stall)
//   d_valid, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
//   d_srcA, d_srcB, d_dstE, d_dstM        decode-stage payload
//   e_valid, e_stat, e_icode, e_ifun, e_valC, e_valA, e_valB,
//   e_srcA, e_srcB, e_dstE, e_dstM        registered execute-stage payload
//   ctl_err                  sticky: stall and bubble were seen together
//   stall_cnt, bubble_cnt    (PIPE_E_PERF_CNT_EN only) performance counters
// ---------------------------------------------------------------------------
module pipe_e_reg
    import y86_pkg::*;
#(
    parameter int WORD_W = 64,
    parameter int REG_W  = 4,
    parameter int STAT_W = 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              e_stall,
    input  logic              e_bubble,
    input  logic              d_valid,
    input  logic [STAT_W-1:0] d_stat,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [WORD_W-1:0] d_valC,
    input  logic [WORD_W-1:0] d_valA,
    input  logic [WORD_W-1:0] d_valB,
    input  logic [REG_W-1:0]  d_srcA,
    input  logic [REG_W-1:0]  d_srcB,
    input  logic [REG_W-1:0]  d_dstE,
    input  logic [REG_W-1:0]  d_dstM,
    output logic              e_valid,
    output logic [STAT_W-1:0] e_stat,
    output logic [3:0]        e_icode,
    output logic [3:0]        e_ifun,
    output logic [WORD_W-1:0] e_valC,
    output logic [WORD_W-1:0] e_valA,
    output logic [WORD_W-1:0] e_valB,
    output logic [REG_W-1:0]  e_srcA,
    output logic [REG_W-1:0]  e_srcB,
    output logic [REG_W-1:0]  e_dstE,
    output logic [REG_W-1:0]  e_dstM,
`ifdef PIPE_E_PERF_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output logic              ctl_err
);

    // Elaboration-time sanity checks on the configuration
    if (STAT_W < 3) begin : g_bad_stat_w
        $error("pipe_e_reg: STAT_W must be at least 3");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_e_reg: CNT_W must be at least 1");
    end

    preg_act_e act;

    assign act = preg_action(rst, e_bubble, e_stall);

    // ---- decode -> execute boundary ----
    // Bubble loads constants only, so X on d_* never reaches e_* during a
    // bubble; a stall keeps the old contents, so d_* is ignored there too.
    always_ff @(posedge clk) begin
        case (act)
            PR_BUBBLE: begin
                e_valid <= 1'b0;
                e_stat  <= STAT_W'(STAT_AOK);
                e_icode <= ICODE_NOP;
                e_ifun  <= 4'h0;
                e_valC  <= '0;
                e_valA  <= '0;
                e_valB  <= '0;
                e_srcA  <= '1;
                e_srcB  <= '1;
                e_dstE  <= '1;
                e_dstM  <= '1;
            end
            PR_LOAD: begin
                e_valid <= d_valid;
                e_stat  <= d_stat;
                e_icode <= d_icode;
                e_ifun  <= d_ifun;
                e_valC  <= d_valC;
                e_valA  <= d_valA;
                e_valB  <= d_valB;
                e_srcA  <= d_srcA;
                e_srcB  <= d_srcB;
                e_dstE  <= d_dstE;
                e_dstM  <= d_dstM;
            end
            default: begin
                // PR_STALL: hold every field, including e_valid
            end
        endcase
    end

    // Sticky control error: only reset clears it
    always_ff @(posedge clk) begin
        if (rst)
            ctl_err <= 1'b0;
        else if (e_stall && e_bubble)
            ctl_err <= 1'b1;
    end

`ifdef PIPE_E_PERF_CNT_EN
    // A stall that coincides with a bubble is counted as a bubble only.
    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .en  (e_stall && !e_bubble),
        .cnt (stall_cnt)
    );

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk (clk),
        .clr (rst),
        .en  (e_bubble),
        .cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_e_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_e_reg
// Self-checking bench for pipe_e_reg: directed steps followed by a random
// phase, all compared against a cycle-level reference model.
// ---------------------------------------------------------------------------
module tb_pipe_e_reg;

    localparam int WORD_W = 64;
    localparam int REG_W  = 4;
    localparam int STAT_W = 3;
    localparam int CNT_W  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              e_stall;
    logic              e_bubble;
    logic              d_valid;
    logic [STAT_W-1:0] d_stat;
    logic [3:0]        d_icode;
    logic [3:0]        d_ifun;
    logic [WORD_W-1:0] d_valC;
    logic [WORD_W-1:0] d_valA;
    logic [WORD_W-1:0] d_valB;
    logic [REG_W-1:0]  d_srcA;
    logic [REG_W-1:0]  d_srcB;
    logic [REG_W-1:0]  d_dstE;
    logic [REG_W-1:0]  d_dstM;
    logic              e_valid;
    logic [STAT_W-1:0] e_stat;
    logic [3:0]        e_icode;
    logic [3:0]        e_ifun;
    logic [WORD_W-1:0] e_valC;
    logic [WORD_W-1:0] e_valA;
    logic [WORD_W-1:0] e_valB;
    logic [REG_W-1:0]  e_srcA;
    logic [REG_W-1:0]  e_srcB;
    logic [REG_W-1:0]  e_dstE;
    logic [REG_W-1:0]  e_dstM;
    logic              ctl_err;
`ifdef PIPE_E_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state: what the execute slot should hold
    logic              m_valid;
    logic [STAT_W-1:0] m_stat;
    logic [3:0]        m_icode, m_ifun;
    logic [WORD_W-1:0] m_valC, m_valA, m_valB;
    logic [REG_W-1:0]  m_srcA, m_srcB, m_dstE, m_dstM;
    logic              m_err;
    int                m_scnt, m_bcnt;

    always #5 clk = ~clk;

    pipe_e_reg #(
        .WORD_W (WORD_W),
        .REG_W  (REG_W),
        .STAT_W (STAT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .e_stall    (e_stall),
        .e_bubble   (e_bubble),
        .d_valid    (d_valid),
        .d_stat     (d_stat),
        .d_icode    (d_icode),
        .d_ifun     (d_ifun),
        .d_valC     (d_valC),
        .d_valA     (d_valA),
        .d_valB     (d_valB),
        .d_srcA     (d_srcA),
        .d_srcB     (d_srcB),
        .d_dstE     (d_dstE),
        .d_dstM     (d_dstM),
        .e_valid    (e_valid),
        .e_stat     (e_stat),
        .e_icode    (e_icode),
        .e_ifun     (e_ifun),
        .e_valC     (e_valC),
        .e_valA     (e_valA),
        .e_valB     (e_valB),
        .e_srcA     (e_srcA),
        .e_srcB     (e_srcB),
        .e_dstE     (e_dstE),
        .e_dstM     (e_dstM),
`ifdef PIPE_E_PERF_CNT_EN
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt),
`endif
        .ctl_err    (ctl_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_nop();
        m_valid = 1'b0;  m_stat = 3'd1;  m_icode = 4'h1;  m_ifun = 4'h0;
        m_valC = '0;     m_valA = '0;    m_valB = '0;
        m_srcA = 4'hF;   m_srcB = 4'hF;  m_dstE = 4'hF;   m_dstM = 4'hF;
    endtask

    // Advance the model by one cycle from the current inputs, clock the DUT,
    // then compare every output just after the edge.
    task automatic tick();
        if (rst) begin
            model_nop();
            m_err = 1'b0;
            m_scnt = 0;
            m_bcnt = 0;
        end else begin
            if (e_bubble) begin
                model_nop();
                if (m_bcnt < CNT_MAX) m_bcnt++;
            end else if (e_stall) begin
                if (m_scnt < CNT_MAX) m_scnt++;
            end else begin
                m_valid = d_valid;  m_stat = d_stat;  m_icode = d_icode;  m_ifun = d_ifun;
                m_valC = d_valC;    m_valA = d_valA;  m_valB = d_valB;
                m_srcA = d_srcA;    m_srcB = d_srcB;  m_dstE = d_dstE;    m_dstM = d_dstM;
            end
            if (e_stall && e_bubble) m_err = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("valid", 64'(e_valid), 64'(m_valid));
        chk("stat",  64'(e_stat),  64'(m_stat));
        chk("icode", 64'(e_icode), 64'(m_icode));
        chk("ifun",  64'(e_ifun),  64'(m_ifun));
        chk("valC",  e_valC, m_valC);
        chk("valA",  e_valA, m_valA);
        chk("valB",  e_valB, m_valB);
        chk("srcA",  64'(e_srcA), 64'(m_srcA));
        chk("srcB",  64'(e_srcB), 64'(m_srcB));
        chk("dstE",  64'(e_dstE), 64'(m_dstE));
        chk("dstM",  64'(e_dstM), 64'(m_dstM));
        chk("ctl_err", 64'(ctl_err), 64'(m_err));
`ifdef PIPE_E_PERF_CNT_EN
        chk("stall_cnt",  64'(stall_cnt),  64'(m_scnt));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bcnt));
`endif
    endtask

    initial begin
        model_nop();
        m_err = 1'b0;  m_scnt = 0;  m_bcnt = 0;
        rst = 1'b1;  e_stall = 1'b0;  e_bubble = 1'b0;
        d_valid = 1'b1;  d_stat = 3'd1;  d_icode = 4'h6;  d_ifun = 4'h0;
        d_valC = '0;  d_valA = 64'h1234;  d_valB = '0;
        d_srcA = 4'h2;  d_srcB = 4'h3;  d_dstE = 4'h3;  d_dstM = 4'hF;
        #2;

        // Reset for two cycles with a live payload on the inputs
        tick();
        tick();
        chk("rst_icode", 64'(e_icode), 64'h1);
        chk("rst_stat",  64'(e_stat),  64'h1);
        chk("rst_dstE",  64'(e_dstE),  64'hF);
        chk("rst_valA",  e_valA,       64'h0);
        chk("rst_valid", 64'(e_valid), 64'h0);
        chk("rst_err",   64'(ctl_err), 64'h0);

        // Plain load
        rst = 1'b0;
        d_icode = 4'h6;  d_ifun = 4'h0;  d_valA = 64'd5;  d_valB = 64'd7;
        d_dstE = 4'h3;  d_valid = 1'b1;
        tick();
        chk("load_icode", 64'(e_icode), 64'h6);
        chk("load_valA",  e_valA,       64'd5);
        chk("load_valB",  e_valB,       64'd7);
        chk("load_dstE",  64'(e_dstE),  64'h3);
        chk("load_valid", 64'(e_valid), 64'h1);

        // Stall for three cycles while decode keeps changing
        e_stall = 1'b1;
        for (int i = 9; i <= 11; i++) begin
            d_valA = 64'(i);
            d_valid = 1'b0;
            tick();
            chk("stall_valA",  e_valA,       64'd5);
            chk("stall_valid", 64'(e_valid), 64'h1);
        end
        e_stall = 1'b0;
        d_valid = 1'b1;
        tick();
        chk("release_valA", e_valA, 64'd11);

        // Bubble, then load the instruction that was waiting
        e_bubble = 1'b1;
        d_icode = 4'h7;  d_valC = 64'h40;
        tick();
        chk("bub_icode", 64'(e_icode), 64'h1);
        chk("bub_valC",  e_valC,       64'h0);
        chk("bub_srcA",  64'(e_srcA),  64'hF);
        chk("bub_valid", 64'(e_valid), 64'h0);
        e_bubble = 1'b0;
        tick();
        chk("post_bub_icode", 64'(e_icode), 64'h7);

        // Stall and bubble together
        e_stall = 1'b1;  e_bubble = 1'b1;  d_icode = 4'h3;
        tick();
        chk("conf_icode", 64'(e_icode), 64'h1);
        chk("conf_err",   64'(ctl_err), 64'h1);
        e_stall = 1'b0;  e_bubble = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("conf_sticky", 64'(ctl_err), 64'h1);
        rst = 1'b1;
        tick();
        chk("conf_clear", 64'(ctl_err), 64'h0);

        // Five stalls then one bubble (counters saturate at 3 with CNT_W=2)
        rst = 1'b0;
        e_stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        e_stall = 1'b0;  e_bubble = 1'b1;
        tick();
`ifdef PIPE_E_PERF_CNT_EN
        chk("cnt_stall_sat", 64'(stall_cnt),  64'd3);
        chk("cnt_bubble",    64'(bubble_cnt), 64'd1);
`endif
        e_bubble = 1'b0;
        rst = 1'b1;
        tick();
`ifdef PIPE_E_PERF_CNT_EN
        chk("cnt_stall_rst",  64'(stall_cnt),  64'd0);
        chk("cnt_bubble_rst", 64'(bubble_cnt), 64'd0);
`endif

        // Random phase
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 39) == 0);
            e_stall  = ($urandom_range(0, 3) == 0);
            e_bubble = ($urandom_range(0, 5) == 0);
            d_valid  = 1'($urandom);
            d_stat   = 3'($urandom);
            d_icode  = 4'($urandom);
            d_ifun   = 4'($urandom);
            d_valC   = {$urandom, $urandom};
            d_valA   = {$urandom, $urandom};
            d_valB   = {$urandom, $urandom};
            d_srcA   = 4'($urandom);
            d_srcB   = 4'($urandom);
            d_dstE   = 4'($urandom);
            d_dstM   = 4'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_e_reg.md
Name: pipe_e_reg

Overview:
- Parametrised decode-to-execute pipeline register for the Y86-64 pipelined core, and the next generation of the plain E register.
- Adds synchronous reset, stall (hold), bubble (inject NOP), and a valid flag.
- Flags a sticky control error when stall and bubble are both asserted.
- Sits between the decode/writeback-select logic and the execute stage; driven by the pipeline control unit.

Parameters:
- WORD_W, 64, data width of valC/valA/valB.
- REG_W, 4, register-ID width of srcA/srcB/dstE/dstM.
- STAT_W, 3, status-code width.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- e_stall  in  1  hold current contents.
- e_bubble  in  1  load NOP bubble.
- d_valid  in  1  decode-stage instruction valid.
- d_stat  in  STAT_W  decode status.
- d_icode  in  4  instruction code.
- d_ifun  in  4  function code.
- d_valC  in  WORD_W  constant word.
- d_valA  in  WORD_W  operand A.
- d_valB  in  WORD_W  operand B.
- d_srcA, d_srcB, d_dstE, d_dstM  in  REG_W each  register IDs.
- e_valid  out  1  execute-stage slot holds a real instruction.
- e_stat, e_icode, e_ifun, e_valC, e_valA, e_valB, e_srcA, e_srcB, e_dstE, e_dstM  out  widths as inputs  registered copies of the d_* fields.
- ctl_err  out  1  sticky: stall and bubble were seen together.

Behaviour:
- All state updates on posedge clk. Non-blocking assignment only. One-cycle latency from d_* to e_*.
- Per-cycle priority: rst > e_bubble > e_stall > load.
- Bubble/reset value:
  - e_stat = STAT_AOK, e_icode = ICODE_NOP (4'h1), e_ifun = 0.
  - e_valC/e_valA/e_valB = 0.
  - e_srcA/e_srcB/e_dstE/e_dstM = RNONE (all ones).
  - e_valid = 0.
- rst also clears ctl_err. rst mid-stall or mid-bubble simply forces the bubble value; no history is kept.
- e_bubble=1 (rst=0): load the bubble value, whatever e_stall is.
- e_stall=1, e_bubble=0: all e_* outputs hold, including e_valid.
- Neither asserted: e_* <= d_*, and e_valid <= d_valid.
- d_valid=0 on a load cycle: the payload is still captured, but e_valid=0. Downstream treats the slot as NOP.
- e_stall & e_bubble in the same cycle:
  - bubble wins.
  - ctl_err <= 1 on that edge and stays 1 until rst.
- No combinational path from any input to any output.
- X on d_* during a bubble or stall must not propagate to the outputs.

Optional Feature:
- Macro PIPE_E_PERF_CNT_EN.
- When defined, two output ports are added:
  - stall_cnt  out  CNT_W: counts cycles with e_stall & ~e_bubble & ~rst.
  - bubble_cnt  out  CNT_W: counts cycles with e_bubble & ~rst.
- Both counters saturate at all-ones (no wrap) and clear to 0 on rst.
- When undefined, neither the ports nor the counter logic exists. All other behaviour is identical either way.

Decomposition:
- Shared package y86_pkg holds ICODE_NOP, STAT_AOK (3'd1), RNONE (4'hF), and the icode/stat localparams used by every pipeline register.
- Sub-module pipe_sat_cnt (parametrised CNT_W saturating counter with clear and enable) is instantiated twice under the macro.
- The payload register itself stays flat.

Test Plan:
- Reset:
  - Drive rst=1 for 2 cycles with d_icode=6, d_valA=0x1234.
  - Required: e_icode=1, e_stat=1, e_dstE=0xF, e_valA=0, e_valid=0, ctl_err=0.
- Load:
  - After reset, d_icode=6, d_ifun=0, d_valA=5, d_valB=7, d_dstE=3, d_valid=1.
  - Required after one edge: e_icode=6, e_valA=5, e_valB=7, e_dstE=3, e_valid=1.
- Stall:
  - Hold e_stall=1 for 3 cycles while d_valA changes 9, 10, 11.
  - Required: e_valA stays 5 and e_valid stays 1. On release, e_valA=11 one edge later.
- Bubble:
  - e_bubble=1 with d_icode=7, d_valC=0x40.
  - Required: e_icode=1, e_valC=0, e_srcA=0xF, e_valid=0.
  - Next cycle with e_bubble=0: e_icode=7.
- Conflict:
  - e_stall=1 and e_bubble=1 together.
  - Required: bubble value loaded and ctl_err=1; ctl_err still 1 after 5 clean cycles; rst clears it.
- Counters (PIPE_E_PERF_CNT_EN, CNT_W=2):
  - 5 stall cycles then 1 bubble cycle.
  - Required: stall_cnt=3 (saturated), bubble_cnt=1. Both read 0 after rst.
